// File: rtl/fir_tdm.sv
// fir_tdm: time-multiplexed FIR filter. A single multiplier-accumulator walks
// the TAPS taps serially, one per clock, then rounds and saturates the result.
module fir_tdm #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned TAPS      = 8,
    parameter int unsigned OUT_SHIFT = 14
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATA_W-1:0]    input_sample,
    input  logic                        coef_we,
    input  logic [$clog2(TAPS)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]    coef_data,
    output logic signed [DATA_W-1:0]    output_sample,
    output logic                        out_valid
);

    localparam int unsigned AW    = $clog2(TAPS);
    localparam int unsigned PW    = DATA_W + COEF_W;
    localparam int unsigned ACC_W = PW + $clog2(TAPS);
    localparam int unsigned RW    = ACC_W + 1;

    localparam logic [AW-1:0]            LAST_IDX  = AW'(TAPS - 1);
    localparam logic [AW:0]              TAPS_W    = (AW + 1)'(TAPS);
    localparam logic signed [RW-1:0]     ROUND_ADD = RW'((2 ** OUT_SHIFT) / 2);
    localparam logic signed [COEF_W-1:0] COEF_ONE  = COEF_W'(2 ** OUT_SHIFT);
    localparam logic signed [RW-1:0]     SAT_MAX   = {{(RW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [RW-1:0]     SAT_MIN   = {{(RW - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MAC  = 1'b1;

    logic [0:0]                r_state;
    logic signed [DATA_W-1:0]  r_x [TAPS];
    logic signed [COEF_W-1:0]  r_c [TAPS];
    logic signed [ACC_W-1:0]   r_acc;
    logic [AW-1:0]             r_idx;
    logic signed [DATA_W-1:0]  r_out;
    logic                      r_out_valid;

    logic [0:0]                w_state_next;
    logic                      w_accept;
    logic                      w_last;
    logic                      w_coef_wr;
    logic signed [PW-1:0]      w_prod;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [RW-1:0]      w_rsum;
    logic signed [RW-1:0]      w_rnd;
    logic signed [DATA_W-1:0]  w_sat;

    assign in_ready      = (r_state == S_IDLE) && !rst;
    assign output_sample = r_out;
    assign out_valid     = r_out_valid;

    // Coefficient writes land only while idle and for in-range addresses.
    assign w_coef_wr = in_ready && coef_we && ({1'b0, coef_addr} < TAPS_W);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: accept in IDLE, leave MAC after the last tap.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_MAC;
                end
            end
            S_MAC: begin
                if (r_idx == LAST_IDX) begin
                    w_last       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // MAC step plus round-half-up and saturation of the running sum.
    always_comb begin
        w_prod     = r_x[r_idx] * r_c[r_idx];
        w_acc_next = r_acc + {{(ACC_W - PW){w_prod[PW-1]}}, w_prod};
        w_rsum     = {w_acc_next[ACC_W-1], w_acc_next} + ROUND_ADD;
        w_rnd      = w_rsum >>> OUT_SHIFT;
        if (w_rnd > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_W-1:0];
        end else if (w_rnd < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_W-1:0];
        end else begin
            w_sat = w_rnd[DATA_W-1:0];
        end
    end

    // Datapath: delay line, coefficient bank, accumulator and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                r_x[k] <= '0;
                r_c[k] <= (k == 0) ? COEF_ONE : '0;
            end
            r_acc       <= '0;
            r_idx       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_coef_wr) begin
                r_c[coef_addr] <= coef_data;
            end
            if (w_accept) begin
                for (int k = int'(TAPS) - 1; k > 0; k--) begin
                    r_x[k] <= r_x[k-1];
                end
                r_x[0] <= input_sample;
                r_acc  <= '0;
                r_idx  <= '0;
            end else if (r_state == S_MAC) begin
                r_acc <= w_acc_next;
                r_idx <= r_idx + AW'(1);
                if (w_last) begin
                    r_out       <= w_sat;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm.sv
// tb_fir_tdm: randomized and directed checks of fir_tdm against an
// arithmetic FIR reference (convolution, round half up, clamp).
module tb_fir_tdm;

    localparam int T  = 8;
    localparam int SH = 14;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [15:0]  input_sample;
    logic                coef_we;
    logic [2:0]          coef_addr;
    logic signed [15:0]  coef_data;
    logic signed [15:0]  output_sample;
    logic                out_valid;

    int checks   = 0;
    int failures = 0;

    int mc [T];
    int mx [T];

    always #5 clk = ~clk;

    fir_tdm dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .input_sample  (input_sample),
        .coef_we       (coef_we),
        .coef_addr     (coef_addr),
        .coef_data     (coef_data),
        .output_sample (output_sample),
        .out_valid     (out_valid)
    );

    function automatic void m_reset();
        for (int k = 0; k < T; k++) begin
            mx[k] = 0;
            mc[k] = 0;
        end
        mc[0] = 1 << SH;
    endfunction

    // Push a sample into the history and return the filtered output.
    function automatic int m_push(input int s);
        longint acc;
        for (int k = T - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = s;
        acc = 0;
        for (int k = 0; k < T; k++) acc += longint'(mx[k]) * longint'(mc[k]);
        acc = (acc + (longint'(1) <<< (SH - 1))) >>> SH;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic write_coef(input logic [2:0] a, input logic signed [15:0] d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        mc[a] = int'(d);
        @(posedge clk);
        #1 coef_we = 1'b0;
    endtask

    // One transaction: wait for ready, offer a sample (optionally with a
    // simultaneous coefficient write or a write poked mid-computation),
    // return the strobed result and its latency in cycles (0 = timeout).
    task automatic do_sample(input logic signed [15:0] s, input bit wr,
                             input logic [2:0] wa, input logic signed [15:0] wd,
                             input bit poke, output logic signed [15:0] got,
                             output int lat, output int exp_v);
        int w;
        lat = 0; got = '0; exp_v = 0;
        @(negedge clk);
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) return;
        in_valid = 1'b1; input_sample = s;
        if (wr) begin
            coef_we = 1'b1; coef_addr = wa; coef_data = wd;
            mc[wa] = int'(wd);
        end
        exp_v = m_push(int'(s));
        @(posedge clk);
        #1 in_valid = 1'b0; coef_we = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (poke && n == 3) begin
                coef_we = 1'b1; coef_addr = 3'($urandom); coef_data = 16'($urandom);
            end else begin
                coef_we = 1'b0;
            end
            if (out_valid === 1'b1) begin
                got = output_sample; lat = n;
                break;
            end
        end
        coef_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (output_sample !== 16'sd0) begin
            failures++; $display("FAIL reset_output: got %0d expected 0", output_sample);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_idle_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_passthrough();
        logic signed [15:0] got, v;
        int lat, e;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            v = (i == 0) ? 16'h1234 : 16'h5678;
            do_sample(v, 1'b0, 3'd0, 16'sd0, 1'b0, got, lat, e);
            checks++;
            if (lat !== 9) begin
                failures++; $display("FAIL pass_latency: got %0d expected 9", lat);
            end
            checks++;
            if (got !== v) begin
                failures++; $display("FAIL pass_value: got %h expected %h", got, v);
            end
        end
    endtask

    task automatic test_impulse();
        logic signed [15:0] got;
        int lat, e;
        do_reset();
        for (int k = 0; k < T; k++) write_coef(3'(k), 16'((k + 1) * 1024));
        for (int k = 0; k < T; k++) begin
            do_sample((k == 0) ? 16'sd16384 : 16'sd0, 1'b0, 3'd0, 16'sd0, 1'b0, got, lat, e);
            checks++;
            if (got !== 16'((k + 1) * 1024) || lat !== 9) begin
                failures++;
                $display("FAIL impulse_%0d: got %0d lat %0d expected %0d lat 9", k, got, lat, (k + 1) * 1024);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] got, v;
        int lat, e;
        do_reset();
        for (int k = 0; k < T; k++) write_coef(3'(k), 16'sd16384);
        for (int p = 0; p < 2; p++) begin
            v = (p == 0) ? 16'h7FFF : 16'h8000;
            for (int k = 0; k < T; k++) begin
                do_sample(v, 1'b0, 3'd0, 16'sd0, 1'b0, got, lat, e);
                checks++;
                if (got !== 16'(e)) begin
                    failures++; $display("FAIL sat_model_%0d_%0d: got %0d expected %0d", p, k, got, e);
                end
            end
            checks++;
            if (got !== v) begin
                failures++; $display("FAIL sat_final_%0d: got %h expected %h", p, got, v);
            end
        end
    endtask

    task automatic test_rounding();
        logic signed [15:0] got;
        logic signed [15:0] ins [3];
        logic signed [15:0] outs [3];
        int lat, e;
        ins[0] = 16'sd8192;  outs[0] = 16'sd1;
        ins[1] = -16'sd8192; outs[1] = 16'sd0;
        ins[2] = 16'sd8191;  outs[2] = 16'sd0;
        do_reset();
        write_coef(3'd0, 16'sd1);
        for (int i = 0; i < 3; i++) begin
            do_sample(ins[i], 1'b0, 3'd0, 16'sd0, 1'b0, got, lat, e);
            checks++;
            if (got !== outs[i] || got !== 16'(e)) begin
                failures++;
                $display("FAIL round_%0d: got %0d expected %0d (model %0d)", i, got, outs[i], e);
            end
        end
    endtask

    task automatic test_handshake();
        localparam int N = 6;
        int n, prev, e;
        int q[$];
        logic signed [15:0] base;
        do_reset();
        for (int k = 0; k < T; k++) write_coef(3'(k), 16'(int'($urandom_range(0, 8191)) - 4096));
        base = 16'($urandom);
        n = 0; prev = -1;
        in_valid = 1'b1; input_sample = base;
        for (int cyc = 0; cyc < 200 && !(n == N && q.size() == 0); cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL hs_extra_output: got %0d with no pending sample", output_sample);
                end else begin
                    e = q.pop_front();
                    if (output_sample !== 16'(e)) begin
                        failures++; $display("FAIL hs_value: got %0d expected %0d", output_sample, e);
                    end
                end
            end
            if (in_ready === 1'b1 && n < N) begin
                q.push_back(m_push(int'(input_sample)));
                if (prev >= 0) begin
                    checks++;
                    if (cyc - prev !== 9) begin
                        failures++; $display("FAIL hs_spacing: got %0d expected 9", cyc - prev);
                    end
                end
                prev = cyc;
                n++;
                @(posedge clk);
                #1;
                if (n < N) input_sample = base + 16'(n * 37);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n != N || q.size() != 0) begin
            failures++; $display("FAIL hs_complete: got accepts %0d pending %0d expected %0d and 0", n, q.size(), N);
        end
    endtask

    task automatic test_coef_busy();
        logic signed [15:0] got;
        int lat, e;
        do_reset();
        for (int k = 0; k < T; k++) write_coef(3'(k), 16'(int'($urandom_range(0, 8191)) - 4096));
        for (int i = 0; i < 5; i++) begin
            do_sample(16'($urandom), 1'b0, 3'd0, 16'sd0, 1'b1, got, lat, e);
            checks++;
            if (got !== 16'(e) || lat !== 9) begin
                failures++; $display("FAIL busy_write_%0d: got %0d lat %0d expected %0d lat 9", i, got, lat, e);
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [15:0] got;
        int lat, e, strobes;
        do_reset();
        for (int k = 0; k < T; k++) write_coef(3'(k), 16'(int'($urandom_range(0, 8191)) - 4096));
        for (int i = 0; i < 3; i++) do_sample(16'($urandom), 1'b0, 3'd0, 16'sd0, 1'b0, got, lat, e);
        @(negedge clk);
        in_valid = 1'b1; input_sample = 16'h4321;
        @(posedge clk);
        #1 in_valid = 1'b0;
        strobes = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 3) rst = 1'b1;
            if (n == 4) rst = 1'b0;
            if (out_valid === 1'b1) strobes++;
        end
        m_reset();
        checks++;
        if (strobes !== 0) begin
            failures++; $display("FAIL abort_strobe: got %0d strobes expected 0", strobes);
        end
        checks++;
        if (output_sample !== 16'sd0) begin
            failures++; $display("FAIL abort_output: got %0d expected 0", output_sample);
        end
        write_coef(3'd1, 16'sd16384);
        do_sample(16'h0100, 1'b0, 3'd0, 16'sd0, 1'b0, got, lat, e);
        checks++;
        if (got !== 16'h0100 || got !== 16'(e)) begin
            failures++; $display("FAIL abort_history: got %h expected 0100 (model %0d)", got, e);
        end
    endtask

    task automatic test_random();
        logic signed [15:0] got;
        int lat, e;
        bit wr;
        do_reset();
        for (int k = 0; k < T; k++) write_coef(3'(k), 16'($urandom));
        for (int i = 0; i < 24; i++) begin
            wr = ($urandom_range(0, 3) == 0);
            do_sample(16'($urandom), wr, 3'($urandom), 16'($urandom), 1'b0, got, lat, e);
            checks++;
            if (got !== 16'(e) || lat !== 9) begin
                failures++; $display("FAIL random_%0d: got %0d lat %0d expected %0d lat 9", i, got, lat, e);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
        input_sample = '0; coef_addr = '0; coef_data = '0;
        m_reset();
        test_reset();
        test_passthrough();
        test_impulse();
        test_saturation();
        test_rounding();
        test_handshake();
        test_coef_busy();
        test_reset_mid_mac();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
